// File: rtl/uart_tx_arbiter.sv
// Round-robin packet arbiter: four byte sources share one UART TX sink.
// Define UART_TX_ARBITER_TIMEOUT_EN to force-release a stalled lock.
module uart_tx_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  in_valid,
    output logic [3:0]  in_ready,
    input  logic [31:0] in_data,
    input  logic [3:0]  in_eop,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [7:0]  out_data,
    output logic [1:0]  grant,
    output logic        busy,
    output logic        timeout
);

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES out of range 2..65535");
    end

    typedef enum logic {
        IDLE,
        LOCK
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  grant_q, grant_d;
    logic [1:0]  last_q, last_d;
    logic [1:0]  pick;
    logic [1:0]  cand;
    logic        any_req;
    logic        xfer;
    logic        eop_xfer;
    logic        force_rel;

    // Highest offset first so the nearest source after last_q wins.
    always_comb begin
        pick = last_q;
        cand = '0;
        for (int k = 3; k >= 0; k--) begin
            cand = last_q + 2'(k + 1);
            if (in_valid[cand]) pick = cand;
        end
    end

    assign any_req = |in_valid;

    always_comb begin
        out_valid = 1'b0;
        out_data  = 8'h00;
        in_ready  = 4'b0000;
        if (state_q == LOCK) begin
            out_valid = in_valid[grant_q];
            if (out_valid) out_data = in_data[{grant_q, 3'b000} +: 8];
            in_ready[grant_q] = out_ready;
        end
    end

    assign xfer     = out_valid & out_ready;
    assign eop_xfer = xfer & in_eop[grant_q];

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    grant_d = pick;
                    state_d = LOCK;
                end
            end
            LOCK: begin
                if (eop_xfer || force_rel) begin
                    last_d  = grant_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            grant_q <= 2'd3;
            last_q  <= 2'd3;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

`ifdef UART_TX_ARBITER_TIMEOUT_EN
    logic [15:0] stall_q;
    logic        timeout_q;

    assign force_rel = (state_q == LOCK) && !xfer &&
                       (stall_q == 16'(TIMEOUT_CYCLES - 1));

    // Counter stays zero outside LOCK, so every lock starts fresh.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= force_rel;
            if (state_q != LOCK || xfer || force_rel) stall_q <= '0;
            else stall_q <= stall_q + 16'd1;
        end
    end

    assign timeout = timeout_q;
`else
    assign force_rel = 1'b0;
    assign timeout   = 1'b0;
`endif

    assign grant = grant_q;
    assign busy  = (state_q == LOCK);

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL provide parameter TIMEOUT_CYCLES, default 4096, meaning the number of stalled cycles before a locked grant is dropped (range 2..65535).
REQ-002 SHALL provide port clk, input, 1 bit, the single rising-edge clock.
REQ-003 SHALL provide port reset_n, input, 1 bit, the reset; it is asynchronous and active-low.
REQ-004 SHALL provide port in_valid, input, 4 bits, per-source byte valid; bit i belongs to source i.
REQ-005 SHALL provide port in_ready, output, 4 bits, per-source byte accepted.
REQ-006 SHALL provide port in_data, input, 32 bits, per-source byte; source i uses [8i+7:8i].
REQ-007 SHALL provide port in_eop, input, 4 bits, per-source end-of-packet, qualified by in_valid.
REQ-008 SHALL provide port out_ready, input, 1 bit, sink ready; it connects to the UART TX phy in_ready.
REQ-009 SHALL provide port out_valid, output, 1 bit, byte valid to the sink.
REQ-010 SHALL provide port out_data, output, 8 bits, byte to the sink.
REQ-011 SHALL provide port grant, output, 2 bits, index of the current or last granted source.
REQ-012 SHALL provide port busy, output, 1 bit, asserted when a source holds the lock.
REQ-013 SHALL provide port timeout, output, 1 bit, a one-cycle pulse on forced release.

Function
REQ-014 SHALL implement an FSM with two states: IDLE (no lock) and LOCK (source grant owns the sink).
REQ-015 SHALL, in IDLE, register out_valid=0, in_ready=0000 and busy=0.
REQ-016 SHALL, in IDLE with any in_valid set, select the first valid source searching upward from last_grant+1, wrapping modulo 4.
REQ-017 SHALL, on that IDLE selection, load grant with the selected index and enter LOCK on the next edge, giving one cycle of arbitration latency.
REQ-018 SHALL, in LOCK, pass source grant combinationally: out_valid=in_valid[grant], out_data=in_data[grant], in_ready[grant]=out_ready, other in_ready bits=0.
REQ-019 SHALL count a byte transfer when out_valid && out_ready.
REQ-020 SHALL, when the transferred byte has in_eop[grant]=1, return to IDLE on the next edge and record last_grant<=grant.
REQ-021 SHALL keep LOCK when the granted source drops in_valid mid-packet; other sources remain blocked.
REQ-022 SHALL treat a single byte carrying eop=1 as a complete one-byte packet.
REQ-023 SHALL not let requests from other sources in the eop transfer cycle bypass round-robin order; they are arbitrated in the following IDLE cycle.
REQ-024 SHALL drive busy=1 exactly while in LOCK.
REQ-025 SHALL hold timeout=0 except on forced release.
REQ-026 SHALL, when only one source requests repeatedly, re-grant it each packet with one IDLE cycle between packets.
REQ-027 SHALL hold out_data at 8'h00 when out_valid=0.

Reset
REQ-028 SHALL, on reset_n low, immediately and asynchronously force state=IDLE, grant=2'd3, last_grant=2'd3, busy=0, out_valid=0, out_data=8'h00, in_ready=0000, timeout=0 and the stall counter=0.
REQ-029 SHALL give source 0 first priority after reset.
REQ-030 SHALL abandon any packet interrupted by reset mid-transfer, with no recovery.
REQ-031 SHALL resume operation on the first clk edge after reset_n deassertion.

Configuration
REQ-032 SHALL, with macro UART_TX_ARBITER_TIMEOUT_EN defined, count LOCK cycles in which no byte transfers; the counter is 16 bits and clears on every transfer and on entering LOCK.
REQ-033 SHALL, when that count reaches TIMEOUT_CYCLES-1 without a transfer, return to IDLE, set last_grant<=grant and pulse timeout for one cycle.
REQ-034 SHALL count sink stalls (out_ready=0) toward the timeout as well as source stalls.
REQ-035 SHALL, without UART_TX_ARBITER_TIMEOUT_EN, hold LOCK indefinitely until eop, tie timeout to 0 and synthesize no counter.

Verification
REQ-036 SHALL cover: after reset, sources 0 and 2 request together with 3-byte packets, out_ready=1 -> grant=0 and bytes 0 then 2, one IDLE cycle between packets.
REQ-037 SHALL cover: all four request continuously with 1-byte packets -> grant sequence 0,1,2,3,0, busy toggling 1,0 per packet.
REQ-038 SHALL cover: source 1 locked, drops valid for 10 cycles mid-packet while source 3 requests -> no source-3 byte until source 1 eop.
REQ-039 SHALL cover: out_ready held 0 for 5 cycles during LOCK -> out_valid=1 and out_data stable, in_ready[grant]=0, no byte lost.
REQ-040 SHALL cover: with UART_TX_ARBITER_TIMEOUT_EN, TIMEOUT_CYCLES=16, locked source stalls -> timeout pulse after 16 stalled cycles, then next source granted; without the macro -> no release.
REQ-041 SHALL cover: reset_n pulsed low mid-packet on source 2 -> outputs at reset values immediately, next grant=0 if source 0 valid.
